// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types and access predicates for the load/store unit
package lsu_pkg;

    typedef enum logic [2:0] {
        F3_LB  = 3'd0,
        F3_LH  = 3'd1,
        F3_LW  = 3'd2,
        F3_LBU = 3'd4,
        F3_LHU = 3'd5
    } load_f3_e;

    typedef enum logic [2:0] {
        F3_SB = 3'd0,
        F3_SH = 3'd1,
        F3_SW = 3'd2
    } store_f3_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_ACCESS2 = 2'd2,
        ST_RESP    = 2'd3
    } state_e;

    // size is funct3[1:0]: 0 byte, 1 halfword, 2 word
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        return ((size == 2'd1) && (off == 2'd3)) || ((size == 2'd2) && (off != 2'd0));
    endfunction

    function automatic logic f3_is_legal(input logic store, input logic [2:0] f3);
        if (store)
            return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
        return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
               (f3 == F3_LBU) || (f3 == F3_LHU);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - byte-lane store rotation, lane masks, and load extraction/extension
module lsu_align (
    input  logic [31:0] i_wdata,
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_off,
    input  logic        i_unsigned,
    input  logic [23:0] i_hi,
    input  logic [31:0] i_lo,
    output logic [31:0] o_wdata,
    output logic [3:0]  o_mask_lo,
    output logic [3:0]  o_mask_hi,
    output logic [31:0] o_rdata
);
    logic [7:0]  w_mask8;
    logic [7:0]  w_base;
    logic [31:0] w_src;

    always_comb begin
        o_wdata = i_wdata;
        w_src   = i_lo;
        case (i_off)
            2'd1: begin
                o_wdata = {i_wdata[23:0], i_wdata[31:24]};
                w_src   = {i_hi[7:0], i_lo[31:8]};
            end
            2'd2: begin
                o_wdata = {i_wdata[15:0], i_wdata[31:16]};
                w_src   = {i_hi[15:0], i_lo[31:16]};
            end
            2'd3: begin
                o_wdata = {i_wdata[7:0], i_wdata[31:8]};
                w_src   = {i_hi[23:0], i_lo[31:24]};
            end
            default: ;
        endcase
    end

    // Lanes past byte 3 spill into the second word of a split access
    always_comb begin
        case (i_size)
            2'd0:    w_base = 8'h01;
            2'd1:    w_base = 8'h03;
            default: w_base = 8'h0F;
        endcase
        w_mask8   = w_base << i_off;
        o_mask_lo = w_mask8[3:0];
        o_mask_hi = w_mask8[7:4];
    end

    always_comb begin
        case (i_size)
            2'd0:    o_rdata = i_unsigned ? {24'd0, w_src[7:0]}  : {{24{w_src[7]}}, w_src[7:0]};
            2'd1:    o_rdata = i_unsigned ? {16'd0, w_src[15:0]} : {{16{w_src[15]}}, w_src[15:0]};
            default: o_rdata = w_src;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32I load/store initiator to word memory; LSU_MISALIGNED_EN enables split misaligned accesses
module load_store_unit
    import lsu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic        resp_err,
    output logic        mem_cs,
    output logic        mem_wr_en,
    output logic        mem_rd_en,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_mask,
    input  logic [31:0] mem_rdata
);
    state_e      r_state;
    logic        r_store;
    logic [2:0]  r_funct3;
    logic [1:0]  r_off;
    logic        r_resp_valid;
    logic [31:0] r_resp_data;
    logic        r_resp_err;
    logic        r_mem_cs;
    logic        r_mem_wr_en;
    logic        r_mem_rd_en;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic [3:0]  r_mem_mask;
`ifdef LSU_MISALIGNED_EN
    logic        r_split;
    logic [3:0]  r_mask_hi;
    logic [31:0] r_lo;
`endif

    logic        w_idle;
    logic        w_err;
    logic        w_last;
    logic [1:0]  w_size;
    logic [1:0]  w_off;
    logic [23:0] w_ext_hi;
    logic [31:0] w_ext_lo;
    logic [31:0] w_al_wdata;
    logic [3:0]  w_mask_lo;
    logic [3:0]  w_mask_hi;
    logic [31:0] w_rdata;

    assign w_idle = (r_state == ST_IDLE);
    assign w_size = w_idle ? req_funct3[1:0] : r_funct3[1:0];
    assign w_off  = w_idle ? req_addr[1:0]   : r_off;

`ifdef LSU_MISALIGNED_EN
    assign w_err    = !f3_is_legal(req_store, req_funct3);
    assign w_last   = (r_state == ST_ACCESS2) || !r_split;
    assign w_ext_hi = (r_state == ST_ACCESS2) ? mem_rdata[23:0] : 24'd0;
    assign w_ext_lo = (r_state == ST_ACCESS2) ? r_lo : mem_rdata;
`else
    assign w_err    = !f3_is_legal(req_store, req_funct3) ||
                      is_misaligned(req_funct3[1:0], req_addr[1:0]);
    assign w_last   = 1'b1;
    assign w_ext_hi = 24'd0;
    assign w_ext_lo = mem_rdata;
`endif

    lsu_align u_align (
        .i_wdata    (req_wdata),
        .i_size     (w_size),
        .i_off      (w_off),
        .i_unsigned (r_funct3[2]),
        .i_hi       (w_ext_hi),
        .i_lo       (w_ext_lo),
        .o_wdata    (w_al_wdata),
        .o_mask_lo  (w_mask_lo),
        .o_mask_hi  (w_mask_hi),
        .o_rdata    (w_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_store      <= 1'b0;
            r_funct3     <= 3'd0;
            r_off        <= 2'd0;
            r_resp_valid <= 1'b0;
            r_resp_data  <= 32'd0;
            r_resp_err   <= 1'b0;
            r_mem_cs     <= 1'b1;
            r_mem_wr_en  <= 1'b1;
            r_mem_rd_en  <= 1'b0;
            r_mem_addr   <= 32'd0;
            r_mem_wdata  <= 32'd0;
            r_mem_mask   <= 4'd0;
`ifdef LSU_MISALIGNED_EN
            r_split      <= 1'b0;
            r_mask_hi    <= 4'd0;
            r_lo         <= 32'd0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_resp_valid <= 1'b0;
                    r_resp_err   <= 1'b0;
                    r_resp_data  <= 32'd0;
                    if (req_valid) begin
                        r_store  <= req_store;
                        r_funct3 <= req_funct3;
                        r_off    <= req_addr[1:0];
                        if (w_err) begin
                            r_state      <= ST_RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b1;
                        end else begin
                            r_state     <= ST_ACCESS;
                            r_mem_cs    <= 1'b0;
                            r_mem_wr_en <= ~req_store;
                            r_mem_rd_en <= ~req_store;
                            r_mem_addr  <= {req_addr[31:2], 2'b00};
                            r_mem_wdata <= w_al_wdata;
`ifdef LSU_MISALIGNED_EN
                            r_mem_mask  <= w_mask_lo;
                            r_mask_hi   <= w_mask_hi;
                            r_split     <= is_misaligned(req_funct3[1:0], req_addr[1:0]);
`else
                            // upper lanes are empty for any access that reaches memory unsplit
                            r_mem_mask  <= w_mask_lo | w_mask_hi;
`endif
                        end
                    end
                end
`ifdef LSU_MISALIGNED_EN
                ST_ACCESS2,
`endif
                ST_ACCESS: begin
`ifdef LSU_MISALIGNED_EN
                    if (r_state == ST_ACCESS)
                        r_lo <= mem_rdata;
                    if (!w_last) begin
                        r_state    <= ST_ACCESS2;
                        r_mem_addr <= r_mem_addr + 32'd4;
                        r_mem_mask <= r_mask_hi;
                    end else
`endif
                    begin
                        r_state      <= ST_RESP;
                        r_mem_cs     <= 1'b1;
                        r_mem_wr_en  <= 1'b1;
                        r_mem_rd_en  <= 1'b0;
                        r_mem_addr   <= 32'd0;
                        r_mem_wdata  <= 32'd0;
                        r_mem_mask   <= 4'd0;
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= 1'b0;
                        r_resp_data  <= r_store ? 32'd0 : w_rdata;
                    end
                end
                ST_RESP: begin
                    r_state      <= ST_IDLE;
                    r_resp_valid <= 1'b0;
                    r_resp_err   <= 1'b0;
                    r_resp_data  <= 32'd0;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign req_ready  = w_idle;
    assign resp_valid = r_resp_valid;
    assign resp_data  = r_resp_data;
    assign resp_err   = r_resp_err;
    assign mem_cs     = r_mem_cs;
    assign mem_wr_en  = r_mem_wr_en;
    assign mem_rd_en  = r_mem_rd_en;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign mem_mask   = r_mem_mask;

endmodule
